// File: rtl/sram1024x18_port_ctrl.sv
// Single-port initiator controller for the 1024x18 SRAM macro.
// Turns a valid/ready request stream into registered SRAM pin activity.
// Read data comes back through a credit-protected FWFT response FIFO.
module sram1024x18_port_ctrl #(
  parameter int AW        = 10,
  parameter int DW        = 18,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_be,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wmsk,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int LW = DW / 2;

  // rd_pipe[1]: read on the pins this cycle; rd_pipe[2]: its data is on sram_rdata
  logic [2:1]    rd_pipe;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          accept, acc_rd, acc_wr, push, pop;

  // Credits cover both in-flight reads and queued responses, so a push
  // can never land on a full FIFO.
  assign inflight  = CW'(rd_pipe[1]) + CW'(rd_pipe[2]);
  assign req_ready = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(RSP_DEPTH);
  assign accept    = req_valid && req_ready;
  assign acc_rd    = accept && !req_we;
  // A write with no lanes enabled is accepted but never touches the RAM.
  assign acc_wr    = accept && req_we && (req_be != 2'b00);
  assign push      = rd_pipe[2];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = fifo_mem[rd_ptr];
  assign busy      = (inflight != '0) || (fifo_count != '0);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Drive SRAM pins one cycle after accept; addr/wdata/wmsk hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_cen   <= 1'b1;
      sram_wen   <= 1'b1;
      sram_addr  <= '0;
      sram_wmsk  <= '1;
      sram_wdata <= '0;
    end else begin
      sram_cen <= 1'b1;
      sram_wen <= 1'b1;
      if (acc_rd) begin
        sram_cen  <= 1'b0;
        sram_addr <= req_addr;
        sram_wmsk <= '1;
      end else if (acc_wr) begin
        sram_cen   <= 1'b0;
        sram_wen   <= 1'b0;
        sram_addr  <= req_addr;
        sram_wdata <= req_wdata;
        sram_wmsk  <= ~{{LW{req_be[1]}}, {LW{req_be[0]}}};
      end
    end
  end

  // Track issued reads so rdata is captured exactly two cycles after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[1] <= acc_rd;
      rd_pipe[2] <= rd_pipe[1];
    end
  end

  // Response FIFO, first-word-fall-through; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= sram_rdata;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram1024x18_port_ctrl.sv
// Directed bench for sram1024x18_port_ctrl with a behavioural masked SRAM.
module tb_sram1024x18_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [9:0]  req_addr;
  logic [1:0]  req_be;
  logic [17:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [17:0] rsp_rdata;
  logic        busy;
  logic        sram_cen, sram_wen;
  logic [9:0]  sram_addr;
  logic [17:0] sram_wmsk, sram_wdata, sram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram1024x18_port_ctrl #(.AW(10), .DW(18), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wmsk(sram_wmsk), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM: masked write (1 = keep), registered read data.
  logic [17:0] smem [1024];
  logic [17:0] srd = '0;
  assign sram_rdata = srd;
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) smem[sram_addr] = (smem[sram_addr] & sram_wmsk) | (sram_wdata & ~sram_wmsk);
      else           srd <= smem[sram_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [1:0]  be;
    logic [17:0] wdata;
    logic        exp_cen;
    logic        exp_wen;
    logic [17:0] exp_wmsk;
    logic [17:0] exp_rsp;
  } vec_t;

  vec_t vt [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, got, first, last, drops, idx;
    logic acc;

    // we addr be wdata | cen wen wmsk rsp
    vt[0] = '{1'b1, 10'h155, 2'b11, 18'h2A5A5, 1'b0, 1'b0, 18'h00000, 18'h0};
    vt[1] = '{1'b0, 10'h155, 2'b00, 18'h00000, 1'b0, 1'b1, 18'h3FFFF, 18'h2A5A5};
    vt[2] = '{1'b1, 10'h3FF, 2'b01, 18'h3FFFF, 1'b0, 1'b0, 18'h3FE00, 18'h0};
    vt[3] = '{1'b0, 10'h3FF, 2'b00, 18'h00000, 1'b0, 1'b1, 18'h3FFFF, 18'h001FF};
    vt[4] = '{1'b1, 10'h0AA, 2'b10, 18'h15555, 1'b0, 1'b0, 18'h001FF, 18'h0};
    vt[5] = '{1'b0, 10'h0AA, 2'b00, 18'h00000, 1'b0, 1'b1, 18'h3FFFF, 18'h15400};
    vt[6] = '{1'b1, 10'h0AA, 2'b00, 18'h00000, 1'b1, 1'b1, 18'h3FFFF, 18'h0};
    vt[7] = '{1'b0, 10'h0AA, 2'b00, 18'h00000, 1'b0, 1'b1, 18'h3FFFF, 18'h15400};

    for (int i = 0; i < 1024; i++) smem[i] = '0;
    for (int i = 0; i < 8; i++) smem[i] = 18'(i * 3);

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("rst_cen",   32'(sram_cen), 1);
    chk("rst_wen",   32'(sram_wen), 1);
    chk("rst_wmsk",  32'(sram_wmsk), 32'h3FFFF);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy",  32'(busy), 0);

    // Table: one request at a time, pins then response
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = vt[i].we; req_addr = vt[i].addr;
      req_be = vt[i].be; req_wdata = vt[i].wdata;
      w = 0;
      while (!req_ready && w < 20) begin step(); w++; end
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 1);
      step();
      req_valid = 1'b0;
      chk($sformatf("v%0d_cen", i),  32'(sram_cen), 32'(vt[i].exp_cen));
      chk($sformatf("v%0d_wen", i),  32'(sram_wen), 32'(vt[i].exp_wen));
      chk($sformatf("v%0d_wmsk", i), 32'(sram_wmsk), 32'(vt[i].exp_wmsk));
      if (!vt[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(sram_addr), 32'(vt[i].addr));
        step();
        chk($sformatf("v%0d_early", i), 32'(rsp_valid), 0);
        step();
        chk($sformatf("v%0d_rvalid", i), 32'(rsp_valid), 1);
        chk($sformatf("v%0d_rdata", i), 32'(rsp_rdata), 32'(vt[i].exp_rsp));
      end
      step();
    end

    // Write then read same address on the next cycle, exact latency
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h155; req_be = 2'b11; req_wdata = 18'h12345;
    chk("wr_rd_ready0", 32'(req_ready), 1);
    step();
    req_we = 1'b0;
    chk("wr_cen", 32'(sram_cen), 0);
    chk("wr_wen", 32'(sram_wen), 0);
    chk("wr_wmsk", 32'(sram_wmsk), 0);
    chk("wr_wdata", 32'(sram_wdata), 32'h12345);
    chk("wr_rd_ready1", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
    chk("rd_cen", 32'(sram_cen), 0);
    chk("rd_wen", 32'(sram_wen), 1);
    step();
    chk("raw_early", 32'(rsp_valid), 0);
    step();
    chk("raw_valid", 32'(rsp_valid), 1);
    chk("raw_data", 32'(rsp_rdata), 32'h12345);
    step();

    // 8 back-to-back reads with consumer always ready
    got = 0; first = -1; last = -1; drops = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'(c);
        if (!req_ready) drops++;
      end else req_valid = 1'b0;
      step();
      if (rsp_valid) begin
        chk($sformatf("b2b_data%0d", got), 32'(rsp_rdata), 32'(got * 3));
        got++;
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("b2b_ready_drops", drops, 0);
    chk("b2b_count", got, 8);
    chk("b2b_first", first, 2);
    chk("b2b_span", last - first, 7);

    // Backpressure: credits stop acceptance at 4 outstanding reads
    rsp_ready = 1'b0; idx = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = (idx < 6); req_we = 1'b0; req_addr = 10'(idx);
      acc = req_valid && req_ready;
      step();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 4);
    chk("bp_ready", 32'(req_ready), 0);
    chk("bp_rvalid", 32'(rsp_valid), 1);
    chk("bp_busy", 32'(busy), 1);
    rsp_ready = 1'b1; got = 0;
    for (int c = 0; c < 30; c++) begin
      req_valid = (idx < 6); req_we = 1'b0; req_addr = 10'(idx);
      acc = req_valid && req_ready;
      if (rsp_valid) begin
        chk($sformatf("bp_data%0d", got), 32'(rsp_rdata), 32'(got * 3));
        got++;
      end
      step();
      if (acc) idx++;
    end
    req_valid = 1'b0;
    chk("bp_rsp_count", got, 6);
    chk("bp_all_accepted", idx, 6);
    chk("bp_idle", 32'(busy), 0);

    // Reset with reads in flight
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd1;
    step();
    req_addr = 10'd2;
    step();
    req_valid = 1'b0;
    chk("mid_busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_cen",   32'(sram_cen), 1);
    chk("mid_wen",   32'(sram_wen), 1);
    chk("mid_addr",  32'(sram_addr), 0);
    chk("mid_wdata", 32'(sram_wdata), 0);
    chk("mid_wmsk",  32'(sram_wmsk), 32'h3FFFF);
    chk("mid_rvalid", 32'(rsp_valid), 0);
    chk("mid_rdata", 32'(rsp_rdata), 0);
    chk("mid_busy",  32'(busy), 0);
    step(); step();
    rst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (rsp_valid) got++;
    end
    chk("mid_no_rsp", got, 0);
    chk("mid_ready", 32'(req_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
